// File: rtl/result_ascii_tx_if.sv
// rtl/result_ascii_tx_if.sv - byte stream handshake bundle for result_ascii_tx
//
// Purpose: carries one ASCII byte per accept (tx_valid && tx_ready on a clock edge).
// Signals:
//   tx_data   8  current byte, driven by the master
//   tx_valid  1  tx_data holds a byte to be taken, driven by the master
//   tx_ready  1  sink accepts on the edge where tx_valid && tx_ready, driven by the slave
interface result_ascii_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/result_ascii_tx.sv
// rtl/result_ascii_tx.sv - formats a 5-bit adder/subtractor result as ASCII "[sign]TO\n"
//
// Purpose: resolves the signed value of an adder/subtractor result (S, C5, E),
// converts its magnitude to two decimal digits by repeated subtraction of ten,
// and streams sign, tens, ones and terminator bytes over a valid/ready stream.
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  asynchronous active-high reset
//   start  in   1  format request, sampled only while idle
//   S      in   5  sum bits
//   C5     in   1  carry out of bit 4
//   E      in   1  overflow flag
//   busy   out  1  high whenever not idle
//   done   out  1  one-cycle pulse after the terminator is accepted
//   tx     master modport of result_ascii_tx_if (tx_data, tx_valid, tx_ready)
module result_ascii_tx #(
    parameter logic [7:0] EOL_CHAR  = 8'd10,
    parameter bit         SHOW_PLUS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4:0]               S,
    input  logic                     C5,
    input  logic                     E,
    output logic                     busy,
    output logic                     done,
    result_ascii_tx_if.master        tx
);

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SIGN,
        TENS,
        ONES,
        EOL
    } state_t;

    state_t     state;
    logic [5:0] mag;
    logic [1:0] tens;
    logic       neg;
    logic [7:0] data_q;
    logic       valid_q;

    // With overflow the carry is the true sign bit, so the value widens to 6 bits.
    logic [5:0] value;
    logic [5:0] mag_in;
    assign value  = E ? {C5, S} : {S[4], S};
    assign mag_in = value[5] ? (6'd0 - value) : value;

    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            mag     <= 6'd0;
            tens    <= 2'd0;
            neg     <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        neg   <= value[5];
                        mag   <= mag_in;
                        tens  <= 2'd0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (mag >= 6'd10) begin
                        mag  <= mag - 6'd10;
                        tens <= tens + 2'd1;
                    end else if (!neg && !SHOW_PLUS) begin
                        data_q  <= 8'h30 + {6'd0, tens};
                        valid_q <= 1'b1;
                        state   <= TENS;
                    end else begin
                        data_q  <= neg ? 8'h2D : 8'h2B;
                        valid_q <= 1'b1;
                        state   <= SIGN;
                    end
                end
                SIGN: begin
                    if (tx.tx_ready) begin
                        data_q <= 8'h30 + {6'd0, tens};
                        state  <= TENS;
                    end
                end
                TENS: begin
                    if (tx.tx_ready) begin
                        data_q <= 8'h30 + {2'd0, mag};
                        state  <= ONES;
                    end
                end
                ONES: begin
                    if (tx.tx_ready) begin
                        data_q <= EOL_CHAR;
                        state  <= EOL;
                    end
                end
                EOL: begin
                    if (tx.tx_ready) begin
                        data_q  <= 8'h00;
                        valid_q <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_ascii_tx.sv
// tb/tb_result_ascii_tx.sv - self-checking bench for result_ascii_tx
module tb_result_ascii_tx;

    typedef struct {
        int         sel;
        logic [4:0] s;
        logic       c5;
        logic       e;
        int         rp;
        bit         poke;
        bit         b2b;
        logic [7:0] b [4];
        int         n;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = 2'b00;
    logic [1:0] rdy = 2'b00;
    logic [4:0] S = 5'd0;
    logic       C5 = 1'b0;
    logic       E = 1'b0;
    logic [1:0] busy;
    logic [1:0] done;
    logic [6:0] pat = 7'b1001011;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    result_ascii_tx_if bus0 ();
    result_ascii_tx_if bus1 ();
    assign bus0.tx_ready = rdy[0];
    assign bus1.tx_ready = rdy[1];

    result_ascii_tx #(.EOL_CHAR(8'd10), .SHOW_PLUS(1'b1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .S(S), .C5(C5), .E(E),
        .busy(busy[0]), .done(done[0]), .tx(bus0.master)
    );

    result_ascii_tx #(.EOL_CHAR(8'd10), .SHOW_PLUS(1'b0)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .S(S), .C5(C5), .E(E),
        .busy(busy[1]), .done(done[1]), .tx(bus1.master)
    );

    function automatic logic get_valid(input int sel);
        return (sel == 1) ? bus1.tx_valid : bus0.tx_valid;
    endfunction

    function automatic logic [7:0] get_data(input int sel);
        return (sel == 1) ? bus1.tx_data : bus0.tx_data;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decode the signed value arithmetically, then build the text line.
    function automatic vec_t model(input int sel, input logic [4:0] s, input logic c5,
                                   input logic e, input int rp);
        vec_t r;
        int v, m;
        bit plus;
        plus = (sel == 0);
        if (e) begin
            v = int'({c5, s});
            if (c5) v = v - 64;
        end else begin
            v = int'(s);
            if (s[4]) v = v - 32;
        end
        m = (v < 0) ? -v : v;
        r.sel = sel; r.s = s; r.c5 = c5; r.e = e; r.rp = rp; r.poke = 0; r.b2b = 0;
        r.n = 0;
        for (int i = 0; i < 4; i++) r.b[i] = 8'h00;
        if (v < 0 || plus) begin
            r.b[r.n] = (v < 0) ? 8'h2D : 8'h2B;
            r.n++;
        end
        r.b[r.n] = 8'(48 + m / 10); r.n++;
        r.b[r.n] = 8'(48 + m % 10); r.n++;
        r.b[r.n] = 8'h0A; r.n++;
        r.lat = m / 10 + 1;
        return r;
    endfunction

    // Issues start at a negedge, drains one line and ends at the negedge of the done cycle.
    task automatic run_line(input vec_t x);
        logic [7:0] got [$];
        int k, vi;
        bit seen, hold, poked;
        logic [7:0] pd, d;
        logic v, r;
        S = x.s; C5 = x.c5; E = x.e;
        start[x.sel] = 1'b1;
        @(posedge clk); @(negedge clk);
        start[x.sel] = 1'b0;
        chk("busy_after_start", busy[x.sel], 1);
        k = 0; vi = 0; seen = 0; hold = 0; poked = 0; pd = 8'h00;
        while (got.size() < x.n && k < 300) begin
            v = get_valid(x.sel);
            d = get_data(x.sel);
            if (v && !seen) begin
                seen = 1;
                chk("first_valid_latency", k, x.lat);
            end
            if (hold) begin
                chk("hold_valid", v, 1);
                chk("hold_data", d, pd);
            end
            if (x.poke && got.size() == 1 && !poked) begin
                start[x.sel] = 1'b1;
                S = ~x.s;
                poked = 1;
            end else begin
                start[x.sel] = 1'b0;
            end
            if (x.rp < 0) r = (vi < 7) ? pat[6 - vi] : 1'b1;
            else r = ($urandom_range(99) < x.rp);
            if (v) vi++;
            rdy[x.sel] = r;
            if (v && r) got.push_back(d);
            hold = v && !r;
            pd = d;
            @(posedge clk); @(negedge clk);
            k++;
        end
        rdy[x.sel] = 1'b0;
        start[x.sel] = 1'b0;
        if (k >= 300) chk("line_timeout", k, 0);
        chk("line_len", got.size(), x.n);
        for (int i = 0; i < x.n; i++)
            chk("byte", (i < got.size()) ? {24'd0, got[i]} : 32'hFFFF, {24'd0, x.b[i]});
        chk("done_pulse", done[x.sel], 1);
        chk("busy_low_at_done", busy[x.sel], 0);
        chk("valid_low_at_done", get_valid(x.sel), 0);
    endtask

    vec_t tbl [8];
    vec_t rv;

    initial begin
        tbl[0] = '{sel:0, s:5'b10001, c5:1, e:0, rp:100, poke:0, b2b:0, b:'{8'h2D, 8'h31, 8'h35, 8'h0A}, n:4, lat:2};
        tbl[1] = '{sel:0, s:5'b11110, c5:0, e:1, rp:100, poke:0, b2b:1, b:'{8'h2B, 8'h33, 8'h30, 8'h0A}, n:4, lat:4};
        tbl[2] = '{sel:0, s:5'b00000, c5:1, e:1, rp:100, poke:0, b2b:0, b:'{8'h2D, 8'h33, 8'h32, 8'h0A}, n:4, lat:4};
        tbl[3] = '{sel:0, s:5'b00000, c5:0, e:0, rp:100, poke:0, b2b:0, b:'{8'h2B, 8'h30, 8'h30, 8'h0A}, n:4, lat:1};
        tbl[4] = '{sel:1, s:5'b00000, c5:0, e:0, rp:100, poke:0, b2b:0, b:'{8'h30, 8'h30, 8'h0A, 8'h00}, n:3, lat:1};
        tbl[5] = '{sel:0, s:5'b00111, c5:0, e:0, rp:-1,  poke:0, b2b:0, b:'{8'h2B, 8'h30, 8'h37, 8'h0A}, n:4, lat:1};
        tbl[6] = '{sel:0, s:5'b10110, c5:0, e:0, rp:100, poke:1, b2b:0, b:'{8'h2D, 8'h31, 8'h30, 8'h0A}, n:4, lat:2};
        tbl[7] = '{sel:1, s:5'b10001, c5:1, e:0, rp:100, poke:0, b2b:0, b:'{8'h2D, 8'h31, 8'h35, 8'h0A}, n:4, lat:2};

        repeat (2) @(negedge clk);
        chk("rst_valid0", bus0.tx_valid, 0);
        chk("rst_data0", bus0.tx_data, 8'h00);
        chk("rst_busy", busy, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_valid1", bus1.tx_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_line(tbl[i]);
            if (!tbl[i].b2b) begin
                @(posedge clk); @(negedge clk);
                chk("done_one_cycle", done[tbl[i].sel], 0);
            end
        end

        // Asynchronous reset while the ones digit is on the bus.
        S = 5'b00111; C5 = 1'b0; E = 1'b0; rdy[0] = 1'b1; start[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        start[0] = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("pre_rst_ones", bus0.tx_data, 8'h37);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", bus0.tx_valid, 0);
        chk("async_rst_busy", busy[0], 0);
        chk("async_rst_data", bus0.tx_data, 8'h00);
        rdy[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_line(model(0, 5'b01101, 1'b0, 1'b0, 100));

        for (int i = 0; i < 40; i++) begin
            rv = model($urandom_range(1), 5'($urandom_range(31)), 1'($urandom_range(1)),
                       1'($urandom_range(1)), $urandom_range(50, 100));
            run_line(rv);
            if ($urandom_range(1) == 1) begin
                @(posedge clk); @(negedge clk);
                chk("done_one_cycle_rand", done[rv.sel], 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/result_ascii_tx.md
# result_ascii_tx

Sequential formatter that takes a finished 5-bit adder/subtractor result (sum bits, final carry, overflow flag), resolves its true signed value and streams it out as ASCII text one byte per handshake: sign, tens digit, ones digit, line terminator. It is the output-side counterpart of the ASCII digit parsing done in front of the adder/subtractor. It sits between the adder/subtractor outputs and any byte-wide character sink (console model, UART transmitter).

## Interface
- EOL_CHAR, 8'd10, terminator byte sent after the ones digit
- SHOW_PLUS, 1, 1 = emit '+' (8'h2B) for non-negative values; 0 = omit the sign byte for non-negative values
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to format; sampled only in IDLE
- S  input  5  adder/subtractor sum bits S[4:0]
- C5  input  1  carry out of bit 4
- E  input  1  overflow flag (C4 xor C5)
- busy  output  1  high in every state except IDLE
- tx_data  output  8  current ASCII byte
- tx_valid  output  1  tx_data holds a byte to be taken
- tx_ready  input  1  sink accepts tx_data on a clock edge where tx_valid && tx_ready
- done  output  1  one-cycle pulse after the terminator is accepted

## Operation
- Value rule: E=0 -> V = S as 5-bit two's complement sign-extended; E=1 -> V = {C5,S} as 6-bit two's complement. V range -32..+31.
- On start in IDLE: latch neg = V<0, mag = |V| (6-bit unsigned, 0..32), tens = 0; go CONV. S/C5/E are ignored after this edge.
- CONV: each cycle, if mag >= 10 then mag -= 10, tens += 1, stay; else go SIGN (or TENS if !neg && SHOW_PLUS==0). tens ends 0..3, mag ends 0..9.
- SIGN: tx_data = neg ? 8'h2D ('-') : 8'h2B ('+'); on accept -> TENS.
- TENS: tx_data = 8'h30 + tens; on accept -> ONES. Leading zero is always sent (two digits fixed).
- ONES: tx_data = 8'h30 + mag; on accept -> EOL.
- EOL: tx_data = EOL_CHAR; on accept -> IDLE with done=1 for that next cycle.
- Value 0 is always formatted as non-negative ("+00" or "00").
- start while busy: ignored, no queuing; includes the cycle done is high (FSM already in IDLE then, so start in that cycle IS accepted).
- No byte is ever skipped or repeated; tx_data and tx_valid change only on an accept edge or a state transition.

## Timing
- Reset (async assert, any state): state=IDLE, busy=0, tx_valid=0, tx_data=8'h00, done=0, internal mag/tens/neg cleared. Partial line is abandoned; no terminator sent.
- Deassert of rst is synchronous-safe: first start is sampled on the first rising edge with rst low.
- Start edge = edge N. busy=1 from after edge N. CONV occupies tens+1 cycles; tx_valid first high after edge N+tens+1.
- tx_valid stays high continuously from first byte until EOL accepted; one byte per edge when tx_ready held high.
- Full line with tx_ready=1: 4 bytes (3 if sign omitted) on consecutive edges; done high the cycle after the last accept; busy low in that same cycle.
- Backpressure: tx_ready low holds tx_data/tx_valid stable indefinitely.
- All outputs registered; no combinational path from start/S/C5/E/tx_ready to any output.

## Test plan
- S=10001, C5=1, E=0, start, tx_ready=1 -> bytes 2D,31,35,0A ("-15\n"); done one cycle after 0A; busy low same cycle.
- S=11110, C5=0, E=1 (15+15) -> 2B,33,30,0A ("+30\n"); tx_valid first high 4 cycles after start edge (3 subtracts + 1).
- S=00000, C5=1, E=1 (-16 + -16) -> 2D,33,32,0A ("-32\n"); S=00000, C5=0, E=0 -> 2B,30,30,0A; with SHOW_PLUS=0 the latter gives 30,30,0A.
- Backpressure: value +7, tx_ready toggled 1,0,0,1,0,1,1 -> sequence 2B,30,37,0A exactly once each, tx_data stable while ready low.
- start pulsed again during TENS with a different S -> ignored, original line completes unchanged; start in done cycle -> new line begins.
- rst asserted asynchronously mid-ONES -> tx_valid, busy, tx_data=00 immediately; after release, next start yields a complete correct line.
